// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, ALUOp and mux-select encodings for the multicycle MIPS control and datapath.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_DONE   = 4'd7,
    S_BR_DONE  = 4'd8,
    S_JMP_DONE = 4'd9
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  function automatic logic op_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: opcode in, datapath control strobes out; master is the controller, slave the datapath.
interface multicycle_control_if;
  logic [5:0] op;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, illegal_op;
  logic [3:0] state_o;
  modport master (
    input  op,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op, state_o
  );
  modport slave (
    output op,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
           pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, illegal_op, state_o
  );
endinterface

// File: rtl/mc_next_state.sv
// mc_next_state: combinational next-state function of the multicycle control FSM.
module mc_next_state
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  output state_t     state_d_o
);
  always_comb begin
    state_d_o = S_FETCH;
    case (state_i)
      S_FETCH:    state_d_o = S_DECODE;
      S_DECODE:   state_d_o = (op_i == OP_LW || op_i == OP_SW) ? S_MEM_ADDR :
                              op_i == OP_RTYPE ? S_EXEC :
                              op_i == OP_BEQ   ? S_BR_DONE :
                              op_i == OP_J     ? S_JMP_DONE : S_FETCH;
      S_MEM_ADDR: state_d_o = op_i == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d_o = S_MEM_WB;
      S_EXEC:     state_d_o = S_R_DONE;
      default:    state_d_o = S_FETCH;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore main control for the multicycle MIPS datapath; outputs decode from state and are held at 0 during reset.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  state_t state_q, state_d;
  mc_next_state u_next (.state_i(state_q), .op_i(bus.op), .state_d_o(state_d));
  always_ff @(posedge clk) state_q <= reset ? S_FETCH : state_d;
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_source     = PCSRC_ALU;
    bus.alu_op        = ALUOP_ADD;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.state_o       = (reset || state_q > S_JMP_DONE) ? 4'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.ir_write  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_write  = 1'b1;
        end
        // branch target precomputed here so BR_DONE only has to compare
        S_DECODE: begin
          bus.alu_src_b  = SRCB_IMM_SH2;
          bus.illegal_op = !op_legal(bus.op);
        end
        S_MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALUOP_FUNCT;
        end
        S_R_DONE: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        S_BR_DONE: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALUOP_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = PCSRC_ALUOUT;
        end
        S_JMP_DONE: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end
endmodule
